// File: rtl/hazard_unit_p_pkg.sv
// Shared definitions for the ID-stage hazard unit: opcodes, forward-select codes, FSM states.
package hazard_unit_p_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_FLUSH} hz_state_e;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction
endpackage

// File: rtl/hazard_unit_p_fwd_sel.sv
// Forward select for one EX operand; EX/MEM takes priority over MEM/WB.
module hz_fwd_sel
    import hazard_unit_p_pkg::*;
#(
    parameter int RA_W      = 5,
    parameter int ZERO_SKIP = 1
) (
    input  logic [RA_W-1:0] src,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_wr,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_wr,
    output logic [1:0]      sel
);
    logic src_ok;
    assign src_ok = !((ZERO_SKIP != 0) && (src == '0));

    always_comb begin
        sel = FWD_RF;
        if (src_ok && exmem_wr && (exmem_rd == src))
            sel = FWD_EXMEM;
        else if (src_ok && memwb_wr && (memwb_rd == src))
            sel = FWD_MEMWB;
    end
endmodule

// File: rtl/hazard_unit_p.sv
// Load-use stall, branch flush and operand forwarding for the 5-stage core.
module hazard_unit_p
    import hazard_unit_p_pkg::*;
#(
    parameter int INS_W        = 32,
    parameter int RA_W         = 5,
    parameter int LOAD_PENALTY = 1,
    parameter int FLUSH_DEPTH  = 1,
    parameter int ZERO_SKIP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INS_W-1:0] id_ins,
    input  logic [INS_W-1:0] ex_ins,
    input  logic             ex_valid,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic             exmem_wr,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic             memwb_wr,
    input  logic [RA_W-1:0]  ex_rs,
    input  logic [RA_W-1:0]  ex_rt,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush,
    output logic [INS_W-1:0] nop,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);
    localparam int NUM_OPS = 2;

    hz_state_e  state;
    logic [2:0] count;

    logic [5:0] id_op, ex_op;
    logic [4:0] id_rs, id_rt, ex_ld_rt;
    logic       hazard;
    logic       unused_ins;

    assign id_op    = id_ins[31:26];
    assign id_rs    = id_ins[25:21];
    assign id_rt    = id_ins[20:16];
    assign ex_op    = ex_ins[31:26];
    assign ex_ld_rt = ex_ins[20:16];
    assign unused_ins = ^{id_ins, ex_ins};

    assign hazard = ex_valid && (ex_op == OP_LW)
                  && !((ZERO_SKIP != 0) && (ex_ld_rt == '0))
                  && ((id_rs == ex_ld_rt) || (reads_rt(id_op) && (id_rt == ex_ld_rt)));

    // Outputs are gated by rst so they fall the instant reset asserts, even with hazard inputs live.
    assign flush = !rst && (branch_taken || (state == ST_FLUSH));
    assign stall = !rst && !flush && ((state == ST_STALL) || ((state == ST_IDLE) && hazard));
    assign nop   = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else if (branch_taken) begin
            if (FLUSH_DEPTH > 1) begin
                state <= ST_FLUSH;
                count <= 3'(FLUSH_DEPTH - 1);
            end else begin
                state <= ST_IDLE;
                count <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hazard && (LOAD_PENALTY > 1)) begin
                        state <= ST_STALL;
                        count <= 3'(LOAD_PENALTY - 1);
                    end
                end
                ST_STALL, ST_FLUSH: begin
                    if (count <= 3'd1) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    logic [NUM_OPS-1:0][RA_W-1:0] op_src;
    logic [NUM_OPS-1:0][1:0]      op_sel;
    assign op_src = {ex_rt, ex_rs};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        hz_fwd_sel #(.RA_W(RA_W), .ZERO_SKIP(ZERO_SKIP)) u_sel (
            .src      (op_src[g]),
            .exmem_rd (exmem_rd),
            .exmem_wr (exmem_wr),
            .memwb_rd (memwb_rd),
            .memwb_wr (memwb_wr),
            .sel      (op_sel[g])
        );
    end

    assign fwd_a = op_sel[0];
    assign fwd_b = op_sel[1];
endmodule

// File: tb/tb_hazard_unit_p.sv
// Scoreboarded directed bench: two configurations (penalty/depth 1/1 and 3/2) share one stimulus stream.
module tb_hazard_unit_p;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_ins, ex_ins;
    logic        ex_valid, exmem_wr, memwb_wr, branch_taken;
    logic [4:0]  exmem_rd, memwb_rd, ex_rs, ex_rt;

    logic        stall1, flush1, stall3, flush3;
    logic [31:0] nop1, nop3;
    logic [1:0]  fa1, fb1, fa3, fb3;

    typedef struct packed {
        logic       s1, f1, s3, f3;
        logic [1:0] fa, fb;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    hazard_unit_p #(.LOAD_PENALTY(1), .FLUSH_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .id_ins(id_ins), .ex_ins(ex_ins), .ex_valid(ex_valid),
        .exmem_rd(exmem_rd), .exmem_wr(exmem_wr), .memwb_rd(memwb_rd), .memwb_wr(memwb_wr),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .stall(stall1), .flush(flush1), .nop(nop1), .fwd_a(fa1), .fwd_b(fb1)
    );

    hazard_unit_p #(.LOAD_PENALTY(3), .FLUSH_DEPTH(2)) dut3 (
        .clk(clk), .rst(rst), .id_ins(id_ins), .ex_ins(ex_ins), .ex_valid(ex_valid),
        .exmem_rd(exmem_rd), .exmem_wr(exmem_wr), .memwb_rd(memwb_rd), .memwb_wr(memwb_wr),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .stall(stall3), .flush(flush3), .nop(nop3), .fwd_a(fa3), .fwd_b(fb3)
    );

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0001};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (entry %0d): got %0h expected %0h", nm, step_no, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each queued expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            step_no++;
            chk("stall_p1", 32'(stall1), 32'(e.s1));
            chk("flush_p1", 32'(flush1), 32'(e.f1));
            chk("stall_p3", 32'(stall3), 32'(e.s3));
            chk("flush_p3", 32'(flush3), 32'(e.f3));
            chk("fwd_a",    32'(fa1),    32'(e.fa));
            chk("fwd_b",    32'(fb1),    32'(e.fb));
            chk("fwd_a_p3", 32'(fa3),    32'(e.fa));
            chk("fwd_b_p3", 32'(fb3),    32'(e.fb));
            chk("nop",      nop1 | nop3, 32'd0);
        end
    end

    task automatic step(input logic s1, input logic f1, input logic s3, input logic f3,
                        input logic [1:0] fa, input logic [1:0] fb);
        exp_q.push_back('{s1, f1, s3, f3, fa, fb});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; id_ins = '0; ex_ins = '0; ex_valid = 1'b0; exmem_rd = '0; exmem_wr = 1'b0;
        memwb_rd = '0; memwb_wr = 1'b0; ex_rs = '0; ex_rt = '0; branch_taken = 1'b0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 2'b00, 2'b00);
        rst = 1'b0;
        step(0, 0, 0, 0, 2'b00, 2'b00);

        // Non-hazards: addi dest matches load, bubble in EX, non-load in EX
        ex_ins = itype(6'b100011, 5'd0, 5'd5); id_ins = itype(6'b001000, 5'd6, 5'd5); ex_valid = 1'b1;
        step(0, 0, 0, 0, 2'b00, 2'b00);
        ex_ins = itype(6'b100011, 5'd0, 5'd2); id_ins = rtype(5'd2, 5'd4, 5'd3); ex_valid = 1'b0;
        step(0, 0, 0, 0, 2'b00, 2'b00);
        ex_ins = itype(6'b001000, 5'd0, 5'd2); ex_valid = 1'b1;
        step(0, 0, 0, 0, 2'b00, 2'b00);

        // lw $2 / add $3,$2,$4: one-cycle vs three-cycle stall
        ex_ins = itype(6'b100011, 5'd0, 5'd2); ex_valid = 1'b1;
        step(1, 0, 1, 0, 2'b00, 2'b00);
        ex_valid = 1'b0;
        step(0, 0, 1, 0, 2'b00, 2'b00);
        step(0, 0, 1, 0, 2'b00, 2'b00);
        step(0, 0, 0, 0, 2'b00, 2'b00);

        // Match on rt of an R-type
        id_ins = rtype(5'd4, 5'd2, 5'd3); ex_valid = 1'b1;
        step(1, 0, 1, 0, 2'b00, 2'b00);
        ex_valid = 1'b0;
        step(0, 0, 1, 0, 2'b00, 2'b00);
        step(0, 0, 1, 0, 2'b00, 2'b00);
        step(0, 0, 0, 0, 2'b00, 2'b00);

        // sw rt hazard, then branch in stall cycle 2 aborts into flush
        id_ins = itype(6'b101011, 5'd4, 5'd2); ex_valid = 1'b1;
        step(1, 0, 1, 0, 2'b00, 2'b00);
        ex_valid = 1'b0; branch_taken = 1'b1;
        step(0, 1, 0, 1, 2'b00, 2'b00);
        branch_taken = 1'b0;
        step(0, 0, 0, 1, 2'b00, 2'b00);
        step(0, 0, 0, 0, 2'b00, 2'b00);

        // Branch coinciding with a hazard: flush wins, no stall
        id_ins = rtype(5'd2, 5'd4, 5'd3); ex_valid = 1'b1; branch_taken = 1'b1;
        step(0, 1, 0, 1, 2'b00, 2'b00);
        ex_valid = 1'b0; branch_taken = 1'b0;
        step(0, 0, 0, 1, 2'b00, 2'b00);
        step(0, 0, 0, 0, 2'b00, 2'b00);

        // Register 0 never hazards or forwards
        ex_ins = itype(6'b100011, 5'd0, 5'd0); id_ins = rtype(5'd0, 5'd0, 5'd3); ex_valid = 1'b1;
        step(0, 0, 0, 0, 2'b00, 2'b00);
        ex_valid = 1'b0; exmem_rd = 5'd0; exmem_wr = 1'b1; ex_rs = 5'd0; ex_rt = 5'd9;
        step(0, 0, 0, 0, 2'b00, 2'b00);

        // Forwarding priority
        exmem_rd = 5'd7; memwb_rd = 5'd7; exmem_wr = 1'b1; memwb_wr = 1'b1; ex_rs = 5'd7; ex_rt = 5'd3;
        step(0, 0, 0, 0, 2'b10, 2'b00);
        exmem_wr = 1'b0;
        step(0, 0, 0, 0, 2'b01, 2'b00);
        ex_rt = 5'd7;
        step(0, 0, 0, 0, 2'b01, 2'b01);
        exmem_wr = 1'b1; exmem_rd = 5'd3; ex_rt = 5'd3;
        step(0, 0, 0, 0, 2'b01, 2'b10);
        memwb_rd = 5'd0; ex_rs = 5'd0;
        step(0, 0, 0, 0, 2'b00, 2'b10);
        exmem_wr = 1'b0; memwb_wr = 1'b0; exmem_rd = '0; ex_rs = '0; ex_rt = '0;

        // Async reset while the 3-cycle unit sits in STALL with count=2
        ex_ins = itype(6'b100011, 5'd0, 5'd2); id_ins = rtype(5'd2, 5'd4, 5'd3); ex_valid = 1'b1;
        step(1, 0, 1, 0, 2'b00, 2'b00);
        rst = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00});
        @(negedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 2'b00, 2'b00);
        step(0, 0, 0, 0, 2'b00, 2'b00);

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
